// File: rtl/inst_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit_pkg
//   Shared constants for the pipelined CPU front end (fetch, decode, hazard).
//   Provides instruction/PC widths, the bubble instruction, the reset PC,
//   the default ROM window and counter widths, the next-PC source encoding
//   and a word-alignment helper.
// -----------------------------------------------------------------------------
package inst_fetch_unit_pkg;

    localparam int          INST_W     = 32;
    localparam int          PC_W       = 32;
    localparam int          ROM_ADDR_W = 6;
    localparam int          FETCH_CNT_W = 16;
    localparam logic [31:0] NOP_INST   = 32'h0000_0000;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;

    // Source of the next PC for one clock edge.
    typedef enum logic [1:0] {
        PC_SRC_HOLD   = 2'd0,
        PC_SRC_BRANCH = 2'd1,
        PC_SRC_SEQ    = 2'd2
    } pc_src_e;

    // Clear the byte-offset bits so the PC always points at a whole word.
    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return addr & ~(PC_W'(3));
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
//   IF/ID pipeline register: fetched instruction, its PC+4, and a valid bit.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     hold            keep all contents (stall); dominates flush
//     flush           insert a bubble: inst=NOP, valid=0, pc4 keeps its value
//     inst_in/pc4_in  values captured on a normal advance
//     inst/pc4/valid  registered outputs
// -----------------------------------------------------------------------------
module if_id_reg
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP = NOP_INST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              flush,
    input  logic [INST_W-1:0] inst_in,
    input  logic [PC_W-1:0]   pc4_in,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   pc4,
    output logic              valid
);

    logic [INST_W-1:0] inst_q, inst_d;
    logic [PC_W-1:0]   pc4_q,  pc4_d;
    logic              valid_q, valid_d;

    always_comb begin
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (hold) begin
            // keep everything
        end else if (flush) begin
            // pc4 is deliberately left alone on a flush
            inst_d  = NOP;
            valid_d = 1'b0;
        end else begin
            inst_d  = inst_in;
            pc4_d   = pc4_in;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q  <= NOP;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign inst  = inst_q;
    assign pc4   = pc4_q;
    assign valid = valid_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//   Instruction-fetch stage. Owns the PC, addresses the instruction ROM,
//   captures the returned word into IF/ID, and applies stall / branch
//   redirect requests from decode (stall beats branch beats sequential).
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     stall             hold PC, IF/ID and counter
//     branch_taken      redirect to branch_target and flush IF/ID
//     branch_target     branch byte address (low two bits ignored)
//     rom_addr          ROM word address = pc[ADDR_W+1:2]
//     rom_inst          ROM data, combinational from rom_addr
//     pc                current fetch PC
//     if_id_inst/pc4/valid  IF/ID register contents
//     fetch_cnt         instructions accepted into IF/ID (wrapping)
//     range_err         sticky flag: PC has been outside the ROM window
// -----------------------------------------------------------------------------
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int          ADDR_W   = ROM_ADDR_W,
    parameter logic [31:0] RESET_PC = inst_fetch_unit_pkg::RESET_PC,
    parameter logic [31:0] NOP_INST = inst_fetch_unit_pkg::NOP_INST,
    parameter int          CNT_W    = FETCH_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_inst,
    output logic [31:0]       pc,
    output logic [31:0]       if_id_inst,
    output logic [31:0]       if_id_pc4,
    output logic              if_id_valid,
    output logic [CNT_W-1:0]  fetch_cnt,
    output logic              range_err
);

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic             range_err_q, range_err_d;
    logic [PC_W-1:0]  pc_plus4;
    pc_src_e          pc_src;

    assign pc_plus4 = pc_q + PC_W'(4);

    always_comb begin
        pc_src      = PC_SRC_SEQ;
        pc_d        = pc_plus4;
        fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
        if (stall) begin
            pc_src      = PC_SRC_HOLD;
            pc_d        = pc_q;
            fetch_cnt_d = fetch_cnt_q;
        end else if (branch_taken) begin
            pc_src      = PC_SRC_BRANCH;
            pc_d        = word_align(branch_target);
            fetch_cnt_d = fetch_cnt_q;
        end
        // Judge the window on the PC being loaded so the flag rises together
        // with the first out-of-window PC rather than a cycle later.
        range_err_d = range_err_q | (|pc_d[PC_W-1:ADDR_W+2]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            fetch_cnt_q <= '0;
            range_err_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            fetch_cnt_q <= fetch_cnt_d;
            range_err_q <= range_err_d;
        end
    end

    if_id_reg #(
        .NOP (NOP_INST)
    ) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold    (pc_src == PC_SRC_HOLD),
        .flush   (pc_src == PC_SRC_BRANCH),
        .inst_in (rom_inst),
        .pc4_in  (pc_plus4),
        .inst    (if_id_inst),
        .pc4     (if_id_pc4),
        .valid   (if_id_valid)
    );

    // Upper PC bits are ignored here, so out-of-window PCs alias into the ROM.
    assign rom_addr  = pc_q[ADDR_W+1:2];
    assign pc        = pc_q;
    assign fetch_cnt = fetch_cnt_q;
    assign range_err = range_err_q;

endmodule
